// File: rtl/alu_exec_pkg.sv
// Shared definitions for the ALU execution unit: op codes, FSM state
// encoding and the iterative mul/div step count.
package alu_exec_pkg;

  localparam int MULDIV_STEPS = 32;
  localparam int CNT_W        = 5;

  // Op codes; 0 is reserved as NOP and broadcasts 0 like any unknown op.
  localparam logic [5:0] OP_NOP    = 6'd0;
  localparam logic [5:0] OP_ADD    = 6'd1;
  localparam logic [5:0] OP_SUB    = 6'd2;
  localparam logic [5:0] OP_AND    = 6'd3;
  localparam logic [5:0] OP_OR     = 6'd4;
  localparam logic [5:0] OP_XOR    = 6'd5;
  localparam logic [5:0] OP_SLL    = 6'd6;
  localparam logic [5:0] OP_SRL    = 6'd7;
  localparam logic [5:0] OP_SRA    = 6'd8;
  localparam logic [5:0] OP_SLT    = 6'd9;
  localparam logic [5:0] OP_SLTU   = 6'd10;
  localparam logic [5:0] OP_EQ     = 6'd11;
  localparam logic [5:0] OP_NE     = 6'd12;
  localparam logic [5:0] OP_LT     = 6'd13;
  localparam logic [5:0] OP_GE     = 6'd14;
  localparam logic [5:0] OP_LTU    = 6'd15;
  localparam logic [5:0] OP_GEU    = 6'd16;
  localparam logic [5:0] OP_LUI    = 6'd17;
  localparam logic [5:0] OP_MUL    = 6'd18;
  localparam logic [5:0] OP_MULH   = 6'd19;
  localparam logic [5:0] OP_MULHSU = 6'd20;
  localparam logic [5:0] OP_MULHU  = 6'd21;
  localparam logic [5:0] OP_DIV    = 6'd22;
  localparam logic [5:0] OP_DIVU   = 6'd23;
  localparam logic [5:0] OP_REM    = 6'd24;
  localparam logic [5:0] OP_REMU   = 6'd25;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } alu_state_e;

  function automatic logic op_is_mul(input logic [5:0] op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU};
  endfunction

  function automatic logic op_is_div(input logic [5:0] op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative 32-step multiply / restoring-divide engine working on operand
// magnitudes; the sign fix-up is folded into the final step's result.
module alu_muldiv_iter
  import alu_exec_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic        step_i,
  input  logic        flush_i,
  input  logic [5:0]  op_i,
  input  logic [31:0] rs1_i,
  input  logic [31:0] rs2_i,
  output logic        done_o,
  output logic [31:0] result_o
);

  logic [63:0]      acc_q, acc_d;
  logic [31:0]      opnd_q, opnd_d;
  logic [CNT_W-1:0] cnt_q;
  logic             is_div_q, sel_hi_q, neg_q;

  logic        a_neg, b_neg, is_div_d, sel_hi_d, neg_d;
  logic [31:0] a_mag, b_mag;

  always_comb begin
    a_neg    = (op_i inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM}) && rs1_i[31];
    b_neg    = (op_i inside {OP_MULH, OP_DIV, OP_REM}) && rs2_i[31];
    a_mag    = a_neg ? -rs1_i : rs1_i;
    b_mag    = b_neg ? -rs2_i : rs2_i;
    is_div_d = op_is_div(op_i);
    sel_hi_d = op_i inside {OP_MULH, OP_MULHSU, OP_MULHU, OP_REM, OP_REMU};
    // A remainder takes the dividend's sign; everything else the XOR of signs.
    neg_d    = (op_i == OP_REM) ? a_neg : (a_neg ^ b_neg);
    // Multiply keeps the multiplier in the low half; divide keeps the dividend.
    acc_d    = is_div_d ? {32'd0, a_mag} : {32'd0, b_mag};
    opnd_d   = is_div_d ? b_mag : a_mag;
  end

  logic [63:0] acc_step, prod;
  logic [32:0] sum33, tmp33;
  logic [31:0] rem_n, q_or_r;
  logic        ge;

  always_comb begin
    sum33    = '0;
    tmp33    = '0;
    rem_n    = '0;
    ge       = 1'b0;
    acc_step = '0;
    prod     = '0;
    q_or_r   = '0;
    result_o = '0;
    if (is_div_q) begin
      tmp33    = {acc_q[63:32], acc_q[31]};
      ge       = tmp33 >= {1'b0, opnd_q};
      rem_n    = ge ? (tmp33[31:0] - opnd_q) : tmp33[31:0];
      acc_step = {rem_n, acc_q[30:0], ge};
      q_or_r   = sel_hi_q ? acc_step[63:32] : acc_step[31:0];
      result_o = neg_q ? -q_or_r : q_or_r;
    end else begin
      sum33    = {1'b0, acc_q[63:32]} + {1'b0, (acc_q[0] ? opnd_q : 32'd0)};
      acc_step = {sum33, acc_q[31:1]};
      prod     = neg_q ? -acc_step : acc_step;
      result_o = sel_hi_q ? prod[63:32] : prod[31:0];
    end
  end

  assign done_o = (cnt_q == CNT_W'(MULDIV_STEPS - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q    <= '0;
      opnd_q   <= '0;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      sel_hi_q <= 1'b0;
      neg_q    <= 1'b0;
    end else if (flush_i) begin
      cnt_q <= '0;
    end else if (start_i) begin
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      cnt_q    <= '0;
      is_div_q <= is_div_d;
      sel_hi_q <= sel_hi_d;
      neg_q    <= neg_d;
    end else if (step_i) begin
      acc_q <= acc_step;
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/alu_exec.sv
// ALU execution unit: single-cycle base ops, iterative mul/div with busy
// back-pressure to the RS, and a registered result broadcast bus.
module alu_exec
  import alu_exec_pkg::*;
#(
  parameter int ROB_ADDR = 4,
  parameter int XLEN     = 32
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                rdy_in,
  input  logic                clear,
  input  logic                issue_valid,
  input  logic [5:0]          issue_op,
  input  logic [XLEN-1:0]     issue_rs1,
  input  logic [XLEN-1:0]     issue_rs2,
  input  logic [ROB_ADDR-1:0] issue_id,
  output logic                alu_busy,
  output logic                alu_valid,
  output logic [ROB_ADDR-1:0] alu_robid,
  output logic [XLEN-1:0]     alu_val
);

  // Handshake: an op transfers on a clock edge where issue_valid && !alu_busy
  // && rdy_in && !clear; the RS holds its entry while alu_busy is high. The
  // result bus has no back-pressure: alu_valid is a one-cycle strobe per tag,
  // held only across cycles where rdy_in is low.
  alu_state_e          state_q;
  logic                valid_q;
  logic [ROB_ADDR-1:0] robid_q, tag_q;
  logic [XLEN-1:0]     val_q;

  logic [XLEN-1:0] base_res;
  logic [4:0]      shamt;
  logic            div_zero, div_ovf, needs_iter, accept;
  logic            eng_done;
  logic [31:0]     eng_res;

  assign shamt = issue_rs2[4:0];

  always_comb begin
    div_zero = (issue_rs2 == '0);
    div_ovf  = ((issue_op == OP_DIV) || (issue_op == OP_REM)) &&
               (issue_rs1 == 32'h8000_0000) && (issue_rs2 == '1);
    base_res = '0;
    case (issue_op)
      OP_ADD:           base_res = issue_rs1 + issue_rs2;
      OP_SUB:           base_res = issue_rs1 - issue_rs2;
      OP_AND:           base_res = issue_rs1 & issue_rs2;
      OP_OR:            base_res = issue_rs1 | issue_rs2;
      OP_XOR:           base_res = issue_rs1 ^ issue_rs2;
      OP_SLL:           base_res = issue_rs1 << shamt;
      OP_SRL:           base_res = issue_rs1 >> shamt;
      OP_SRA:           base_res = $signed(issue_rs1) >>> shamt;
      OP_SLT, OP_LT:    base_res = XLEN'($signed(issue_rs1) < $signed(issue_rs2));
      OP_SLTU, OP_LTU:  base_res = XLEN'(issue_rs1 < issue_rs2);
      OP_EQ:            base_res = XLEN'(issue_rs1 == issue_rs2);
      OP_NE:            base_res = XLEN'(issue_rs1 != issue_rs2);
      OP_GE:            base_res = XLEN'($signed(issue_rs1) >= $signed(issue_rs2));
      OP_GEU:           base_res = XLEN'(issue_rs1 >= issue_rs2);
      OP_LUI:           base_res = issue_rs2;
      // Only reached for the zero-divisor / overflow shortcuts.
      OP_DIV, OP_DIVU:  base_res = div_zero ? '1 : 32'h8000_0000;
      OP_REM, OP_REMU:  base_res = div_zero ? issue_rs1 : '0;
      default:          base_res = '0;
    endcase
    needs_iter = op_is_mul(issue_op) || (op_is_div(issue_op) && !div_zero && !div_ovf);
  end

  assign accept = issue_valid && (state_q == ST_IDLE) && rdy_in && !clear;

  alu_muldiv_iter u_iter (
    .clk_i    (clk_in),
    .rst_ni   (rst_in),
    .start_i  (accept && needs_iter),
    .step_i   (rdy_in && !clear && (state_q != ST_IDLE)),
    .flush_i  (rdy_in && clear),
    .op_i     (issue_op),
    .rs1_i    (issue_rs1),
    .rs2_i    (issue_rs2),
    .done_o   (eng_done),
    .result_o (eng_res)
  );

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= ST_IDLE;
      valid_q <= 1'b0;
      robid_q <= '0;
      tag_q   <= '0;
      val_q   <= '0;
    end else if (rdy_in) begin
      if (clear) begin
        state_q <= ST_IDLE;
        valid_q <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            valid_q <= 1'b0;
            if (issue_valid) begin
              if (needs_iter) begin
                state_q <= op_is_mul(issue_op) ? ST_MUL : ST_DIV;
                tag_q   <= issue_id;
              end else begin
                valid_q <= 1'b1;
                robid_q <= issue_id;
                val_q   <= base_res;
              end
            end
          end
          default: begin
            valid_q <= 1'b0;
            if (eng_done) begin
              state_q <= ST_IDLE;
              valid_q <= 1'b1;
              robid_q <= tag_q;
              val_q   <= eng_res;
            end
          end
        endcase
      end
    end
  end

  assign alu_busy  = (state_q != ST_IDLE);
  assign alu_valid = valid_q;
  assign alu_robid = robid_q;
  assign alu_val   = val_q;

endmodule

// File: tb/tb_alu_exec.sv
// Directed bench for alu_exec: stimulus pushes {cycle, tag, value} into a
// scoreboard queue; a negedge monitor pops and compares each broadcast.
module tb_alu_exec;
  import alu_exec_pkg::*;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, clear, issue_valid;
  logic [5:0]  issue_op;
  logic [31:0] issue_rs1, issue_rs2;
  logic [3:0]  issue_id;
  logic        alu_busy, alu_valid;
  logic [3:0]  alu_robid;
  logic [31:0] alu_val;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  logic [67:0] exp_q[$];
  logic [67:0] mon_e;

  alu_exec #(.ROB_ADDR(4), .XLEN(32)) dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .rdy_in      (rdy_in),
    .clear       (clear),
    .issue_valid (issue_valid),
    .issue_op    (issue_op),
    .issue_rs1   (issue_rs1),
    .issue_rs2   (issue_rs2),
    .issue_id    (issue_id),
    .alu_busy    (alu_busy),
    .alu_valid   (alu_valid),
    .alu_robid   (alu_robid),
    .alu_val     (alu_val)
  );

  // Clock / cycle counter
  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drivers
  task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] id, input bit push, input logic [31:0] ev,
                       input int lat);
    @(posedge clk_in); #1;
    issue_valid = 1'b1;
    issue_op    = op;
    issue_rs1   = a;
    issue_rs2   = b;
    issue_id    = id;
    if (push) exp_q.push_back({32'(cyc + lat), id, ev});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_in); #1;
      issue_valid = 1'b0;
    end
  endtask

  task automatic md(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                    input logic [3:0] id, input logic [31:0] ev);
    issue(op, a, b, id, 1'b1, ev, 33);
    idle(32);
  endtask

  // Scoreboard monitor
  always @(negedge clk_in) begin
    if (rst_in && rdy_in && alu_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_broadcast tag=%0d val=%h (cycle %0d)", alu_robid, alu_val, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("bcast_tag",   {28'd0, alu_robid}, {28'd0, mon_e[35:32]});
        chk("bcast_val",   alu_val,            mon_e[31:0]);
        chk("bcast_cycle", cyc,                mon_e[67:36]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_in = 1'b0; rdy_in = 1'b1; clear = 1'b0; issue_valid = 1'b0;
    issue_op = '0; issue_rs1 = '0; issue_rs2 = '0; issue_id = '0;
    repeat (3) @(negedge clk_in);
    chk("rst_valid", {31'd0, alu_valid}, 32'd0);
    chk("rst_robid", {28'd0, alu_robid}, 32'd0);
    chk("rst_val",   alu_val,            32'd0);
    chk("rst_busy",  {31'd0, alu_busy},  32'd0);
    rst_in = 1'b1;

    issue(OP_ADD, 32'd5, 32'd7, 4'd3, 1'b1, 32'd12, 1);
    idle(2);

    issue(OP_SUB, 32'd1, 32'd2, 4'd1, 1'b1, 32'hFFFF_FFFF, 1);
    issue(OP_SRA, 32'h8000_0000, 32'd4, 4'd2, 1'b1, 32'hF800_0000, 1);
    issue(OP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 4'd3, 1'b1, 32'hF000_F000, 1);
    issue(OP_OR,  32'hF0F0_F0F0, 32'hFF00_FF00, 4'd4, 1'b1, 32'hFFF0_FFF0, 1);
    issue(OP_XOR, 32'hF0F0_F0F0, 32'hFF00_FF00, 4'd5, 1'b1, 32'h0FF0_0FF0, 1);
    issue(OP_SLL, 32'd1, 32'd33, 4'd6, 1'b1, 32'd2, 1);
    issue(OP_SRL, 32'h8000_0000, 32'd4, 4'd7, 1'b1, 32'h0800_0000, 1);
    issue(OP_SLT, 32'hFFFF_FFFF, 32'd5, 4'd8, 1'b1, 32'd1, 1);
    issue(OP_SLTU, 32'hFFFF_FFFF, 32'd5, 4'd9, 1'b1, 32'd0, 1);
    issue(OP_EQ, 32'd9, 32'd9, 4'd10, 1'b1, 32'd1, 1);
    issue(OP_NE, 32'd9, 32'd9, 4'd11, 1'b1, 32'd0, 1);
    issue(OP_GE, 32'd3, 32'hFFFF_FFFE, 4'd12, 1'b1, 32'd1, 1);
    issue(OP_LTU, 32'd3, 32'hFFFF_FFFF, 4'd13, 1'b1, 32'd1, 1);
    issue(OP_GEU, 32'd3, 32'hFFFF_FFFF, 4'd14, 1'b1, 32'd0, 1);
    issue(OP_LUI, 32'd77, 32'h1234_5000, 4'd15, 1'b1, 32'h1234_5000, 1);
    issue(6'd63, 32'd1, 32'd1, 4'd1, 1'b1, 32'd0, 1);
    issue(OP_NOP, 32'd1, 32'd1, 4'd2, 1'b1, 32'd0, 1);
    idle(2);

    // MULH with an ignored ADD mid-flight
    issue(OP_MULH, 32'hFFFF_FFFE, 32'd3, 4'd5, 1'b1, 32'hFFFF_FFFF, 33);
    for (int k = 1; k <= 33; k++) begin
      @(posedge clk_in); #1;
      issue_valid = (k == 10);
      if (k == 10) begin
        issue_op = OP_ADD; issue_rs1 = 32'd1; issue_rs2 = 32'd1; issue_id = 4'd9;
      end
      @(negedge clk_in);
      if (k == 1 || k == 32) chk("busy_during_mul", {31'd0, alu_busy}, 32'd1);
      if (k == 33)           chk("busy_after_mul",  {31'd0, alu_busy}, 32'd0);
    end

    md(OP_MUL,    32'h1234_5678, 32'h10,        4'd1, 32'h2345_6780);
    md(OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd2, 32'hFFFF_FFFE);
    md(OP_MULHSU, 32'hFFFF_FFFF, 32'd2,         4'd3, 32'hFFFF_FFFF);
    md(OP_MULH,   32'h8000_0000, 32'h8000_0000, 4'd4, 32'h4000_0000);
    md(OP_DIVU,   32'd100,       32'd7,         4'd5, 32'd14);
    md(OP_DIV,    32'hFFFF_FFF9, 32'd2,         4'd6, 32'hFFFF_FFFD);
    md(OP_REM,    32'hFFFF_FFF9, 32'd2,         4'd7, 32'hFFFF_FFFF);
    md(OP_REMU,   32'd100,       32'd7,         4'd8, 32'd2);
    md(OP_REM,    32'd7,         32'hFFFF_FFFE, 4'd9, 32'd1);

    // Division shortcuts resolve in one cycle
    issue(OP_DIV,  32'd7,         32'd0,         4'd10, 1'b1, 32'hFFFF_FFFF, 1);
    issue(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 4'd11, 1'b1, 32'd0, 1);
    issue(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 4'd12, 1'b1, 32'h8000_0000, 1);
    issue(OP_REMU, 32'd55,        32'd0,         4'd13, 1'b1, 32'd55, 1);
    issue(OP_DIVU, 32'd5,         32'd0,         4'd14, 1'b1, 32'hFFFF_FFFF, 1);
    idle(2);

    // Clear kills an in-flight DIV
    issue(OP_DIV, 32'd1000, 32'd3, 4'd7, 1'b0, 32'd0, 0);
    for (int k = 1; k <= 17; k++) begin
      @(posedge clk_in); #1;
      issue_valid = 1'b0;
      clear = (k == 15);
      if (k == 15) begin
        issue_valid = 1'b1; issue_op = OP_ADD; issue_rs1 = 32'd2; issue_rs2 = 32'd2; issue_id = 4'd6;
      end
      if (k == 16) begin
        issue_valid = 1'b1; issue_op = OP_ADD; issue_rs1 = 32'd20; issue_rs2 = 32'd22; issue_id = 4'd8;
        exp_q.push_back({32'(cyc + 1), 4'd8, 32'd42});
      end
      @(negedge clk_in);
      if (k == 16) chk("busy_after_clear", {31'd0, alu_busy}, 32'd0);
    end
    idle(25);

    // Clear in IDLE drops the op issued in the same cycle
    issue(OP_ADD, 32'd3, 32'd4, 4'd10, 1'b0, 32'd0, 0);
    clear = 1'b1;
    @(posedge clk_in); #1;
    clear = 1'b0; issue_valid = 1'b0;
    idle(3);

    // rdy_in low for 5 cycles mid-MUL stretches latency by 5
    issue(OP_MUL, 32'd7, 32'd6, 4'd4, 1'b1, 32'd42, 38);
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk_in); #1;
      issue_valid = 1'b0;
      rdy_in = !(k >= 10 && k <= 14);
    end
    idle(2);

    // Async reset in the middle of an op
    issue(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd11, 1'b0, 32'd0, 0);
    idle(5);
    #3;
    rst_in = 1'b0;
    #1;
    chk("async_rst_valid", {31'd0, alu_valid}, 32'd0);
    chk("async_rst_robid", {28'd0, alu_robid}, 32'd0);
    chk("async_rst_val",   alu_val,            32'd0);
    chk("async_rst_busy",  {31'd0, alu_busy},  32'd0);
    repeat (2) @(negedge clk_in);
    rst_in = 1'b1;

    md(OP_MUL, 32'd3, 32'd5, 4'd12, 32'd15);
    issue(OP_ADD, 32'd100, 32'd23, 4'd13, 1'b1, 32'd123, 1);
    idle(5);

    @(negedge clk_in);
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_exec.md
Name: alu_exec

Overview:
- Execution unit at the far end of the reservation-station issue interface.
- Consumes one issued op per accept: operands, 6-bit op and RoB tag.
- Broadcasts the result on the ALU result bus (alu_valid/alu_robid/alu_val), which the RS, LSB and RoB snoop for dependency wake-up.
- Base RV32I ops complete in 1 cycle. RV32M mul/div ops run an iterative 32-step engine, and the block asserts busy during that time so the RS holds issue.

Parameters:
- ROB_ADDR, 4, RoB tag width (equals `RoB_addr).
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- clk_in  in  1  clock.
- rst_in  in  1  asynchronous active-low reset.
- rdy_in  in  1  global enable; when low, all state freezes.
- clear  in  1  RoB misprediction flush; synchronous.
- issue_valid  in  1  RS presents an op this cycle.
- issue_op  in  6  op code (`OP_* in const.v).
- issue_rs1  in  32  operand 1.
- issue_rs2  in  32  operand 2 (register value or immediate).
- issue_id  in  ROB_ADDR  destination RoB tag.
- alu_busy  out  1  iterative op in flight; RS must not pop an entry.
- alu_valid  out  1  result broadcast strobe.
- alu_robid  out  ROB_ADDR  tag of the broadcast result.
- alu_val  out  32  result value.

Behaviour:
Reset and clear
- Reset (rst_in=0, async): alu_valid=0, alu_robid=0, alu_val=0, alu_busy=0, state=IDLE, counter=0.
- clear=1 (with rdy_in=1) at an edge: go to IDLE and set alu_valid=0 next cycle. Any op issued that cycle is dropped, and any in-flight mul/div result is dropped.
- clear has priority over issue.

States
- IDLE, MUL, DIV.
- alu_busy = (state != IDLE); it is a combinational function of the registered state.

Accept rule
- An op is accepted when issue_valid && state==IDLE && rdy_in && !clear.
- issue_valid while busy is ignored; it is the RS's responsibility to hold.

Base ops (ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU, EQ, NE, LT, GE, LTU, GEU, LUI-pass)
- Result is registered; alu_valid=1 in cycle T+1 for exactly one cycle, where T is the accept cycle.
- Shift amount is rs2[4:0].
- Compare ops return 32'd1 or 32'd0.
- A back-to-back accept every cycle yields one broadcast per cycle.

MUL, MULH, MULHSU, MULHU
- On accept, latch the magnitudes and the result sign; MULHSU treats rs1 as signed and rs2 as unsigned.
- Enter MUL and run 32 shift-add steps on a 64-bit accumulator, one per cycle, with counter 0..31.
- At counter==31, negate if the result sign is set. Output low 32 bits for MUL, high 32 bits otherwise.
- alu_valid is high in cycle T+33. The block returns to IDLE in that same cycle, so a new accept is possible at T+33.

DIV, DIVU, REM, REMU
- 32-step restoring division on magnitudes, with signs applied at the end. Latency is the same as MUL (T+33).
- Special cases resolve at accept with 1-cycle latency and no DIV state:
  - Divide by zero: quotient = 32'hFFFFFFFF, remainder = rs1.
  - Signed overflow (rs1=32'h80000000, rs2=-1): quotient = 32'h80000000, remainder = 0.

Other rules
- Unknown op: broadcast 0 with 1-cycle latency; never hang.
- rdy_in=0: counter, state and outputs hold. alu_valid is held, and consumers also gate on rdy_in.
- alu_valid is never high for two cycles with the same tag, except while rdy_in is low.

Decomposition:
- const.v gains `OP_* codes (6-bit, value 0 reserved as NOP) and `MULDIV_STEPS=32.
- One sub-module, alu_muldiv_iter, holds the iterative engine: start, op, operands → done, result. alu_exec keeps the FSM, the base-op datapath and the output register.

Test Plan:
- Reset then ADD rs1=5, rs2=7, id=3 at T → alu_valid=1, alu_robid=3, alu_val=12 at T+1 only; outputs 0 during reset.
- Back-to-back SUB 1-2 (id 1) then SRA 32'h80000000>>4 (id 2) → broadcasts 32'hFFFFFFFF and 32'hF8000000 on consecutive cycles.
- MULH rs1=-2, rs2=3, id=5 → alu_busy=1 for T+1..T+32, alu_val=32'hFFFFFFFF at T+33. An ADD issued at T+10 is ignored.
- DIV 7/0 → 32'hFFFFFFFF at T+1; REM 32'h80000000 % -1 → 0 at T+1; DIVU 100/7 → 14 at T+33.
- DIV in flight with clear at T+15 → no broadcast, alu_busy=0 at T+16; ADD issued at T+16 broadcasts at T+17.
- rdy_in low for 5 cycles mid-MUL → result latency extends by exactly 5 cycles with the correct value; async reset asserted mid-op → immediate IDLE with all outputs 0.
